// File: rtl/ave8_seq_ctrl.sv
// Sequencing controller for the 8-tap moving-average datapath: input flow control,
// warm-up gating, result FIFO and flush (drain, clear, restart warm-up).
module ave8_seq_ctrl #(
  parameter int DW       = 8,
  parameter int TAPS     = 8,
  parameter int CNT_W    = 4,
  parameter int OF_DEPTH = 4
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          flush,
  output logic          dp_shift,
  output logic [DW-1:0] dp_in,
  output logic          dp_clr,
  input  logic [DW-1:0] dp_avg,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          warm,
  output logic          busy
);

  localparam int PW = (OF_DEPTH > 1) ? $clog2(OF_DEPTH) : 1;
  localparam int CW = $clog2(OF_DEPTH + 1);

  typedef enum logic [1:0] {FILL, RUN, DRAIN, CLR} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] fill_cnt_q;
  logic             cap_q;

  logic [DW-1:0]    mem_q [OF_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CW:0]      occ;
  logic             accept;
  logic             push;
  logic             pop;

  // A pending capture reserves a FIFO slot, so admission counts it as occupied.
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, cap_q};
  assign in_ready = ~RESET && ((state_q == FILL) || (state_q == RUN)) &&
                    (occ < (CW+1)'(OF_DEPTH));
  assign accept   = in_valid && in_ready;
  assign dp_shift = accept;
  assign dp_in    = in_data;

  assign dp_clr   = (state_q == CLR);
  assign warm     = (state_q == RUN);
  assign busy     = (state_q == DRAIN) || (state_q == CLR);

  assign push      = cap_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      cap_q      <= 1'b0;
    end else begin
      cap_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (accept) begin
            if (fill_cnt_q == CNT_W'(TAPS - 1)) begin
              cap_q      <= 1'b1;
              fill_cnt_q <= CNT_W'(TAPS);
              state_q    <= RUN;
            end else begin
              fill_cnt_q <= fill_cnt_q + CNT_W'(1);
            end
          end
          // Flush wins the state transition but the accept above still captures.
          if (flush) state_q <= DRAIN;
        end
        RUN: begin
          if (accept) cap_q <= 1'b1;
          if (flush) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!cap_q && (count_q == '0)) state_q <= CLR;
        end
        CLR: begin
          fill_cnt_q <= '0;
          state_q    <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(OF_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OF_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: out_data is gated by the occupancy count.
  always_ff @(posedge CLOCK) begin
    if (push) mem_q[wr_ptr_q] <= dp_avg;
  end

endmodule
